// File: rtl/store_trace_display_if.sv
// Store-side view of the core's M stage as seen by the trace monitor.
// There is no handshake: the core drives these every cycle and the monitor never stalls it.
interface store_trace_display_if;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;

   modport master (output MemWriteM, output ALUResultM, output WriteDataM);
   modport slave  (input  MemWriteM, input  ALUResultM, input  WriteDataM);
endinterface

// File: rtl/store_trace_display.sv
// Basys3 debug monitor: records data-memory stores into a small ring buffer
// and shows latest/history/count/data on the 16 LEDs with an activity stretcher.
module store_trace_display #(
   parameter int DEPTH     = 8,
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int STRETCH   = 10_000_000,
   parameter int CNT_W     = 16
) (
   input  logic                       CLK100MHZ,
   input  logic                       rst_BTN,
   store_trace_display_if.slave       bus,
   input  logic                       freeze,
   input  logic [1:0]                 mode,
   input  logic [$clog2(DEPTH)-1:0]   sel,
   output logic [15:0]                LED,
   output logic                       overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ACT_W = $clog2(STRETCH + 1);

   logic [15:0]      hist [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic [CNT_W-1:0] store_cnt;
   logic [ACT_W-1:0] act_cnt;
   logic [14:0]      data_hi;

   logic             capture;
   logic             act;
   logic [PTR_W-1:0] newest_idx;
   logic [PTR_W-1:0] sel_idx;
   logic [15:0]      newest_entry;
   logic [15:0]      sel_entry;

   logic unused_bus_bits;
   assign unused_bus_bits = ^{bus.ALUResultM[31:ADDR_BITS], bus.WriteDataM[31:15]};

   // Counter and stretcher keep running while frozen; only the history is held.
   assign capture = bus.MemWriteM && !freeze;
   assign act     = (act_cnt != '0);

   always_ff @(posedge CLK100MHZ or posedge rst_BTN) begin
      if (rst_BTN) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         data_hi  <= '0;
      end else if (capture) begin
         hist[wr_ptr] <= {bus.ALUResultM[ADDR_BITS-1:0], bus.WriteDataM[DATA_BITS-1:0]};
         wr_ptr       <= wr_ptr + PTR_W'(1);
         data_hi      <= bus.WriteDataM[14:0];
         if (count < (PTR_W+1)'(DEPTH)) count    <= count + (PTR_W+1)'(1);
         else                           overflow <= 1'b1;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge rst_BTN) begin
      if (rst_BTN) begin
         store_cnt <= '0;
         act_cnt   <= '0;
      end else begin
         if (bus.MemWriteM) store_cnt <= store_cnt + CNT_W'(1);
         if (bus.MemWriteM)  act_cnt <= ACT_W'(STRETCH);
         else if (act)       act_cnt <= act_cnt - ACT_W'(1);
      end
   end

   // Entry k lives k slots behind the newest; slots beyond count read as zero.
   always_comb begin
      newest_idx   = wr_ptr - PTR_W'(1);
      sel_idx      = newest_idx - sel;
      newest_entry = (count != '0) ? hist[newest_idx] : 16'h0000;
      sel_entry    = ({1'b0, sel} < count) ? hist[sel_idx] : 16'h0000;
   end

   always_comb begin
      LED = 16'h0000;
      case (mode)
         2'b00:   LED = newest_entry | {act, 15'h0000};
         2'b01:   LED = sel_entry;
         2'b10:   LED = store_cnt[15:0];
         default: LED = {act, data_hi};
      endcase
   end
endmodule

// File: tb/tb_store_trace_display.sv
// Self-checking bench for store_trace_display (DEPTH=8, STRETCH=10).
module tb_store_trace_display;
   localparam int DEPTH   = 8;
   localparam int STRETCH = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [2:0]  sel = 3'd0;
   logic [15:0] led;
   logic        ovf;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_v;

   store_trace_display_if bus ();

   store_trace_display #(
      .DEPTH(DEPTH), .ADDR_BITS(8), .DATA_BITS(8), .STRETCH(STRETCH), .CNT_W(16)
   ) dut (
      .CLK100MHZ(clk), .rst_BTN(rst), .bus(bus.slave), .freeze(freeze),
      .mode(mode), .sel(sel), .LED(led), .overflow(ovf)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #3;
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Drives one store for one edge; returns at the negedge right after that edge.
   task automatic store(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.MemWriteM  = 1'b1;
      bus.ALUResultM = {24'($urandom), a};
      bus.WriteDataM = {16'($urandom), d};
      @(negedge clk);
      bus.MemWriteM  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #1;
      for (int m = 0; m < 4; m++) begin
         mode = m[1:0];
         #1;
         checks++;
         if (led !== 16'h0000) begin
            failures++;
            $display("FAIL reset_led mode=%0d got=%h exp=0000", m, led);
         end
      end
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf got=%b exp=0", ovf);
      end
      rst = 1'b0;
      mode = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      store(8'h01, 16'h0011);
      store(8'h02, 16'h0022);
      store(8'h03, 16'h0033);
      mode = 2'b10;
      #1;
      checks++;
      if (led !== 16'h0003) begin
         failures++;
         $display("FAIL pre_reset_cnt got=%h exp=0003", led);
      end
      #1;
      rst = 1'b1;
      bus.MemWriteM = 1'b1;
      #1;
      checks++;
      if (led !== 16'h0000 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_cnt got=%h ovf=%b exp=0000 ovf=0", led, ovf);
      end
      mode = 2'b00;
      #1;
      checks++;
      if (led !== 16'h0000) begin
         failures++;
         $display("FAIL mid_reset_newest got=%h exp=0000", led);
      end
      @(negedge clk);
      bus.MemWriteM = 1'b0;
      rst = 1'b0;
      mode = 2'b10;
      #1;
      checks++;
      if (led !== 16'h0000) begin
         failures++;
         $display("FAIL reset_wins_cnt got=%h exp=0000", led);
      end
   endtask

   task automatic test_stretch();
      do_reset();
      mode = 2'b00;
      store(8'h34, 16'h56A5);
      for (int k = 0; k < 12; k++) exp_q.push_back((k < STRETCH) ? 16'hB4A5 : 16'h34A5);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (led !== exp_v) begin
            failures++;
            $display("FAIL stretch k=%0d got=%h exp=%h", k, led, exp_v);
         end
      end
      mode = 2'b11;
      #1;
      checks++;
      if (led !== 16'h56A5) begin
         failures++;
         $display("FAIL data_hi got=%h exp=56A5", led);
      end
   endtask

   task automatic test_history();
      logic [2:0] sels [4];
      sels[0] = 3'd0; sels[1] = 3'd2; sels[2] = 3'd3; sels[3] = 3'd1;
      do_reset();
      store(8'h01, 16'h0011);
      store(8'h02, 16'h0022);
      store(8'h03, 16'h0033);
      mode = 2'b01;
      exp_q.push_back(16'h0333);
      exp_q.push_back(16'h0111);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0222);
      for (int i = 0; i < 4; i++) begin
         sel = sels[i];
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (led !== exp_v) begin
            failures++;
            $display("FAIL history sel=%0d got=%h exp=%h", sel, led, exp_v);
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      mode = 2'b01;
      for (int i = 0; i < DEPTH; i++) store(8'h40 + 8'(i), 16'(i));
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_full got=%b exp=0", ovf);
      end
      store(8'h48, 16'h0008);
      exp_q.push_back(16'h4101);
      exp_q.push_back(16'h4808);
      sel = 3'd7;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (led !== exp_v || ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_oldest got=%h ovf=%b exp=%h ovf=1", led, ovf, exp_v);
      end
      sel = 3'd0;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (led !== exp_v) begin
         failures++;
         $display("FAIL ovf_newest got=%h exp=%h", led, exp_v);
      end
      idle(20);
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%b exp=1", ovf);
      end
      do_reset();
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_cleared got=%b exp=0", ovf);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      store(8'h77, 16'h1288);
      idle(STRETCH + 2);
      freeze = 1'b1;
      for (int i = 0; i < 5; i++) store(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
      exp_q.push_back(16'h0006);
      exp_q.push_back(16'h7788);
      exp_q.push_back(16'h1288);
      exp_q.push_back(16'h0000);
      mode = 2'b10;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (led !== exp_v) begin
         failures++;
         $display("FAIL freeze_cnt got=%h exp=%h", led, exp_v);
      end
      idle(STRETCH + 2);
      mode = 2'b00;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (led !== exp_v) begin
         failures++;
         $display("FAIL freeze_newest got=%h exp=%h", led, exp_v);
      end
      mode = 2'b11;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (led !== exp_v) begin
         failures++;
         $display("FAIL freeze_data_hi got=%h exp=%h", led, exp_v);
      end
      mode = 2'b01;
      sel = 3'd1;
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (led !== exp_v) begin
         failures++;
         $display("FAIL freeze_count got=%h exp=%h", led, exp_v);
      end
      freeze = 1'b0;
      // Full buffer: frozen stores must not raise overflow, the next live one must.
      do_reset();
      for (int i = 0; i < DEPTH; i++) store(8'(i), 16'(i));
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) store(8'hEE, 16'h00EE);
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL freeze_no_ovf got=%b exp=0", ovf);
      end
      freeze = 1'b0;
      store(8'h99, 16'h0055);
      sel = 3'd0;
      #1;
      checks++;
      if (ovf !== 1'b1 || led !== 16'h9955) begin
         failures++;
         $display("FAIL unfreeze_ovf got=%h ovf=%b exp=9955 ovf=1", led, ovf);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      mode = 2'b00;
      store(8'h10, 16'h0001);
      for (int k = 0; k < 18; k++)
         exp_q.push_back(((k < 4) ? 16'h1001 : 16'h2002) | ((k < 14) ? 16'h8000 : 16'h0000));
      for (int k = 0; k < 18; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 4) bus.MemWriteM = 1'b0;
         exp_v = exp_q.pop_front();
         checks++;
         if (led !== exp_v) begin
            failures++;
            $display("FAIL back_to_back k=%0d got=%h exp=%h", k, led, exp_v);
         end
         if (k == 3) begin
            bus.MemWriteM  = 1'b1;
            bus.ALUResultM = 32'hDEAD_BE20;
            bus.WriteDataM = 32'hCAFE_0002;
         end
      end
   endtask

   initial begin
      bus.MemWriteM  = 1'b0;
      bus.ALUResultM = '0;
      bus.WriteDataM = '0;
      test_reset();
      test_reset_mid();
      test_stretch();
      test_history();
      test_overflow();
      test_freeze();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
